// File: rtl/alu_exec_if.sv
// Handshake and operand/result bundle between the decode stage, alu_exec and its consumer.
interface alu_exec_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUctr;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Zero;
  logic        Overflow;
  logic        Illegal;

  modport master (
    output in_valid, ALUctr, A, B, shamt, out_ready,
    input  in_ready, out_valid, Result, Zero, Overflow, Illegal
  );

  modport slave (
    input  in_valid, ALUctr, A, B, shamt, out_ready,
    output in_ready, out_valid, Result, Zero, Overflow, Illegal
  );
endinterface

// File: rtl/alu_exec.sv
// MIPS-style execute ALU: single-cycle arithmetic/logic ops, bit-serial shifts (one bit per cycle),
// valid/ready handshakes on both sides and fully registered outputs.
module alu_exec (
  input logic       Clk,
  input logic       Reset,
  alu_exec_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  typedef enum logic [3:0] {
    OP_ADDU = 4'b0000, OP_ADD  = 4'b0001, OP_SUBU = 4'b0010, OP_SUB  = 4'b0011,
    OP_AND  = 4'b0100, OP_OR   = 4'b0101, OP_XOR  = 4'b0110, OP_NOR  = 4'b0111,
    OP_SLT  = 4'b1000, OP_SLTU = 4'b1001, OP_SLL  = 4'b1010, OP_SRL  = 4'b1011,
    OP_SRA  = 4'b1100, OP_LUI  = 4'b1101
  } op_e;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] sh_q, sh_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;
  logic        ill_q, ill_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;

  logic [31:0] sum, diff, alu_res, shift1;
  logic        alu_ovf, alu_ill, is_shift;

  // Single-cycle datapath, evaluated on the live inputs and captured on the accept edge.
  always_comb begin
    sum      = bus.A + bus.B;
    diff     = bus.A - bus.B;
    alu_res  = '0;
    alu_ovf  = 1'b0;
    alu_ill  = 1'b0;
    is_shift = (bus.ALUctr == OP_SLL) || (bus.ALUctr == OP_SRL) || (bus.ALUctr == OP_SRA);
    case (bus.ALUctr)
      OP_ADDU: alu_res = sum;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.A[31] == bus.B[31]) && (sum[31] != bus.A[31]);
      end
      OP_SUBU: alu_res = diff;
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.A[31] != bus.B[31]) && (diff[31] != bus.A[31]);
      end
      OP_AND:  alu_res = bus.A & bus.B;
      OP_OR:   alu_res = bus.A | bus.B;
      OP_XOR:  alu_res = bus.A ^ bus.B;
      OP_NOR:  alu_res = ~(bus.A | bus.B);
      OP_SLT:  alu_res = {31'b0, $signed(bus.A) < $signed(bus.B)};
      OP_SLTU: alu_res = {31'b0, bus.A < bus.B};
      OP_SLL, OP_SRL, OP_SRA: alu_res = bus.B;
      OP_LUI:  alu_res = {bus.B[15:0], 16'h0000};
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_SLL:  shift1 = {sh_q[30:0], 1'b0};
      OP_SRL:  shift1 = {1'b0, sh_q[31:1]};
      default: shift1 = {sh_q[31], sh_q[31:1]};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    ill_d       = ill_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          op_d  = bus.ALUctr;
          sh_d  = bus.B;
          cnt_d = bus.shamt;
          if (is_shift && (bus.shamt != '0)) begin
            state_d = SHIFT;
          end else begin
            state_d     = DONE;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            ovf_d       = alu_ovf;
            ill_d       = alu_ill;
            out_valid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        sh_d  = shift1;
        cnt_d = cnt_q - 5'd1;
        // The last shift step writes the result directly so DONE follows exactly n SHIFT cycles.
        if (cnt_q == 5'd1) begin
          state_d     = DONE;
          result_d    = shift1;
          zero_d      = (shift1 == '0);
          ovf_d       = 1'b0;
          ill_d       = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      sh_q        <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Result    = result_q;
  assign bus.Zero      = zero_q;
  assign bus.Overflow  = ovf_q;
  assign bus.Illegal   = ill_q;
endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed vector table, randomized ops against a plain-arithmetic model,
// and hand-written handshake/reset sequences.
module tb_alu_exec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_exec_if bus ();

  alu_exec dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    int          hold;
    logic [31:0] res;
    logic        z;
    logic        ovf;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] sh, input int hold, input logic [31:0] res,
                              input logic z, input logic ovf, input logic ill, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.sh = sh; v.hold = hold;
    v.res = res; v.z = z; v.ovf = ovf; v.ill = ill; v.lat = lat;
    return v;
  endfunction

  // Reference: true-integer arithmetic; overflow is "the exact signed result does not fit in 32 bits".
  function automatic void ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] sh, output logic [31:0] res,
                                    output logic ovf, output logic ill, output int lat);
    longint sa, sb, exact;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 32'h0; ovf = 1'b0; ill = 1'b0;
    case (op)
      4'd0, 4'd1: begin exact = sa + sb; res = 32'(exact); ovf = (op == 4'd1) && (longint'($signed(res)) != exact); end
      4'd2, 4'd3: begin exact = sa - sb; res = 32'(exact); ovf = (op == 4'd3) && (longint'($signed(res)) != exact); end
      4'd4: res = a & b;
      4'd5: res = a | b;
      4'd6: res = a ^ b;
      4'd7: res = ~(a | b);
      4'd8: res = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: res = (a < b) ? 32'd1 : 32'd0;
      4'd10: res = b << sh;
      4'd11: res = b >> sh;
      4'd12: res = $signed(b) >>> sh;
      4'd13: res = {b[15:0], 16'h0000};
      default: ill = 1'b1;
    endcase
    lat = ((op >= 4'd10) && (op <= 4'd12) && (sh != 5'd0)) ? int'(sh) + 1 : 1;
  endfunction

  // Issues one op at a negedge, scrambles inputs after accept, holds out_ready low for
  // `hold` cycles in DONE, then handshakes and checks the return to IDLE.
  task automatic run_check(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh, input int hold,
                           input logic [31:0] e_res, input logic e_z, input logic e_ovf,
                           input logic e_ill, input int e_lat);
    int guard, lat, busy, unstable;
    logic [31:0] r0;
    logic z0, o0, i0;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin @(negedge clk); guard++; end
    chk({tag, ".ready_wait"}, {31'b0, bus.in_ready}, 32'd1);
    bus.ALUctr = op; bus.A = a; bus.B = b; bus.shamt = sh;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.ALUctr = 4'($urandom); bus.A = $urandom; bus.B = $urandom; bus.shamt = 5'($urandom);
    lat = 1; busy = 0;
    forever begin
      if (!bus.in_ready) busy++;
      if (bus.out_valid || lat >= 40) break;
      bus.in_valid = 1'($urandom);
      bus.ALUctr = 4'($urandom); bus.B = $urandom; bus.shamt = 5'($urandom);
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    chk({tag, ".latency"}, 32'(lat), 32'(e_lat));
    chk({tag, ".result"}, bus.Result, e_res);
    chk({tag, ".zero"}, {31'b0, bus.Zero}, {31'b0, e_z});
    chk({tag, ".overflow"}, {31'b0, bus.Overflow}, {31'b0, e_ovf});
    chk({tag, ".illegal"}, {31'b0, bus.Illegal}, {31'b0, e_ill});
    r0 = bus.Result; z0 = bus.Zero; o0 = bus.Overflow; i0 = bus.Illegal;
    unstable = 0;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'($urandom); bus.A = $urandom; bus.ALUctr = 4'($urandom);
      @(negedge clk);
      if (!bus.in_ready) busy++;
      if (!bus.out_valid || bus.Result !== r0 || bus.Zero !== z0 ||
          bus.Overflow !== o0 || bus.Illegal !== i0) unstable++;
    end
    if (hold > 0) chk({tag, ".hold_stable"}, 32'(unstable), 32'd0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ".busy_cycles"}, 32'(busy), 32'(e_lat + hold));
    chk({tag, ".post_valid"}, {31'b0, bus.out_valid}, 32'd0);
    chk({tag, ".post_ready"}, {31'b0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b, eres;
    logic [4:0]  sh;
    logic        eovf, eill;
    int          elat, seen;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.ALUctr = '0; bus.A = '0; bus.B = '0; bus.shamt = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst.result", bus.Result, 32'd0);
    chk("rst.flags", {29'b0, bus.Zero, bus.Overflow, bus.Illegal}, 32'd0);
    chk("rst.in_ready_held", {31'b0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.in_ready_release", {31'b0, bus.in_ready}, 32'd1);

    //            op      A             B             sh  hold res           z     ovf   ill   lat
    tbl.push_back(mk(4'h1, 32'h7FFFFFFF, 32'h00000001, 5'd0,  0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1));
    tbl.push_back(mk(4'h0, 32'h7FFFFFFF, 32'h00000001, 5'd0,  0, 32'h80000000, 1'b0, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'h3, 32'h00000005, 32'h00000005, 5'd0,  0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'h8, 32'hFFFFFFFF, 32'h00000001, 5'd0,  0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'h9, 32'hFFFFFFFF, 32'h00000001, 5'd0,  0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'hC, 32'h00000000, 32'h80000000, 5'd4,  0, 32'hF8000000, 1'b0, 1'b0, 1'b0, 5));
    tbl.push_back(mk(4'hA, 32'h00000000, 32'h00001234, 5'd0,  0, 32'h00001234, 1'b0, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'h4, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  3, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'hE, 32'h00000001, 32'h00000002, 5'd7,  0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1));
    tbl.push_back(mk(4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1));
    tbl.push_back(mk(4'h3, 32'h80000000, 32'h00000001, 5'd0,  0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1));
    tbl.push_back(mk(4'h2, 32'h00000000, 32'h00000001, 5'd0,  0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'hD, 32'h00000000, 32'hABCD1234, 5'd9,  0, 32'h12340000, 1'b0, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'h7, 32'h00000000, 32'h00000000, 5'd0,  0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'h6, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd0,  0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'h5, 32'h00000000, 32'h00000000, 5'd0,  1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'hB, 32'h00000000, 32'hFFFFFFFF, 5'd31, 0, 32'h00000001, 1'b0, 1'b0, 1'b0, 32));
    tbl.push_back(mk(4'hA, 32'h00000000, 32'h00000001, 5'd31, 2, 32'h80000000, 1'b0, 1'b0, 1'b0, 32));
    tbl.push_back(mk(4'hC, 32'h00000000, 32'h40000000, 5'd1,  0, 32'h20000000, 1'b0, 1'b0, 1'b0, 2));

    for (int i = 0; i < tbl.size(); i++)
      run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, tbl[i].hold,
                tbl[i].res, tbl[i].z, tbl[i].ovf, tbl[i].ill, tbl[i].lat);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? a : $urandom;
      sh = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      ref_model(op, a, b, sh, eres, eovf, eill, elat);
      run_check($sformatf("rnd%0d", i), op, a, b, sh, $urandom_range(0, 2),
                eres, (eres == 32'h0), eovf, eill, elat);
    end

    // No accept in DONE even with out_ready and in_valid high together; next accept one cycle later.
    bus.ALUctr = 4'h0; bus.A = 32'd3; bus.B = 32'd4; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("done_noaccept.valid", {31'b0, bus.out_valid}, 32'd1);
    chk("done_noaccept.result", bus.Result, 32'd7);
    bus.A = 32'd10; bus.B = 32'd10; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("done_noaccept.dropped", {31'b0, bus.out_valid}, 32'd0);
    chk("done_noaccept.idle_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("done_noaccept.second_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("done_noaccept.second_result", bus.Result, 32'd20);
    @(negedge clk);
    bus.out_ready = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.out_valid || !bus.in_ready) seen++;
    end
    chk("idle_hold", 32'(seen), 32'd0);

    // Reset ten cycles into a 31-step SLL aborts it.
    bus.ALUctr = 4'hA; bus.A = '0; bus.B = 32'd1; bus.shamt = 5'd31; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("rst_shift.busy", {31'b0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_shift.out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_shift.result", bus.Result, 32'd0);
    chk("rst_shift.flags", {29'b0, bus.Zero, bus.Overflow, bus.Illegal}, 32'd0);
    chk("rst_shift.in_ready_held", {31'b0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_shift.in_ready_release", {31'b0, bus.in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("rst_shift.no_result", 32'(seen), 32'd0);

    // Reset in DONE wins over a concurrent handshake and a concurrent request.
    bus.ALUctr = 4'h1; bus.A = 32'h7FFFFFFF; bus.B = 32'd1; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rst_done.valid", {31'b0, bus.out_valid}, 32'd1);
    rst = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    bus.ALUctr = 4'h0; bus.A = 32'd1; bus.B = 32'd1;
    @(negedge clk);
    chk("rst_done.out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_done.result", bus.Result, 32'd0);
    chk("rst_done.overflow", {31'b0, bus.Overflow}, 32'd0);
    chk("rst_done.in_ready", {31'b0, bus.in_ready}, 32'd0);
    rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    chk("rst_done.release", {31'b0, bus.in_ready}, 32'd1);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("rst_done.no_result", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
